// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the RV64 pipeline. Memory-wait, branch-flush and
// load-use hazards are resolved in a fixed priority each cycle.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RD_E,
  input  logic             MemReadE,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic             PCSrcM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_memop;
  logic       w_in_err;
  logic       w_mem_stall;
  logic       w_hold_all;
  logic       w_branch;
  logic       w_load_use;
  logic       w_stall_front;
  logic       w_timeout;
  logic [8:0] w_wait_next;

  assign w_memop     = MemReadM | MemWriteM;
  assign w_in_err    = (r_state == ERROR);
  assign w_mem_stall = !w_in_err && w_memop && !dmem_ready;
  assign w_hold_all  = w_in_err || w_mem_stall;

  // Lower-priority hazards are masked by any higher one; a held MEM stage
  // re-presents its branch once the memory access completes.
  assign w_branch   = !w_hold_all && PCSrcM;
  assign w_load_use = !w_hold_all && !PCSrcM && MemReadE && (RD_E != 5'd0) &&
                      ((RD_E == Rs1D) || (RD_E == Rs2D));

  assign w_stall_front = w_hold_all || w_load_use;
  assign w_wait_next   = {1'b0, r_wait_cnt} + 9'd1;
  assign w_timeout     = w_mem_stall && (w_wait_next == 9'(MEM_TIMEOUT));

  // While reset is high every stage is bubbled and nothing is held.
  assign StallF   = !reset && w_stall_front;
  assign StallD   = !reset && w_stall_front;
  assign StallE   = !reset && w_hold_all;
  assign StallM   = !reset && w_hold_all;
  assign FlushD   = reset || w_branch;
  assign FlushE   = reset || w_branch || w_load_use;
  assign FlushM   = reset || w_branch;
  assign FlushW   = reset || w_hold_all;
  assign dmem_req = !reset && !w_in_err && w_memop;

  assign mem_timeout_err = r_err;
  assign stall_count     = r_stall_cnt;
  assign flush_count     = r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      // NOTE: non-blocking updates so every decision below uses pre-edge state.
      r_wait_cnt <= w_mem_stall ? w_wait_next[7:0] : 8'd0;

      case (r_state)
        RUN, MEM_WAIT: begin
          if (w_timeout) begin
            r_state <= ERROR;
            r_err   <= 1'b1;
          end else if (w_mem_stall) begin
            r_state <= MEM_WAIT;
          end else begin
            r_state <= RUN;
          end
        end
        ERROR:   r_state <= ERROR;
        default: r_state <= RUN;
      endcase

      if (w_stall_front && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_branch && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then
// random traffic, checked against a priority-rule reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    Rs1D = '0, Rs2D = '0, RD_E = '0;
  logic          MemReadE = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0;
  logic          PCSrcM = 1'b0, dmem_ready = 1'b0;
  logic          dmem_req, StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushM, FlushW, mem_timeout_err;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD_E(RD_E),
    .MemReadE(MemReadE), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .PCSrcM(PCSrcM), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .mem_timeout_err(mem_timeout_err), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       mre, mrm, mwm, pcs, rdy, rst;
  } stim_t;

  typedef struct {
    logic [3:0] stall;  // {F,D,E,M}
    logic [3:0] flush;  // {D,E,M,W}
    logic       req, err;
    int         sc, fc;
    string      tag;
  } exp_t;

  typedef enum {K_NONE, K_HALT, K_MEMW, K_BR, K_LU} kind_t;

  exp_t q[$];
  bit   m_err;
  int   m_run, m_sc, m_fc;
  int   n_vec, n_miss;

  function automatic stim_t mk(int rs1, int rs2, int rd, bit mre, bit mrm,
                               bit mwm, bit pcs, bit rdy, bit rst);
    stim_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.mre = mre; s.mrm = mrm; s.mwm = mwm; s.pcs = pcs; s.rdy = rdy; s.rst = rst;
    return s;
  endfunction

  // Which priority rule governs this cycle.
  function automatic kind_t kind_of(stim_t s);
    if (m_err) return K_HALT;
    if ((s.mrm || s.mwm) && !s.rdy) return K_MEMW;
    if (s.pcs) return K_BR;
    if (s.mre && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2)) return K_LU;
    return K_NONE;
  endfunction

  function automatic exp_t predict(stim_t s, string tag);
    exp_t e;
    kind_t k;
    e.tag = tag;
    if (s.rst) begin
      e.stall = 4'b0000; e.flush = 4'b1111; e.req = 1'b0;
      e.err = 1'b0; e.sc = 0; e.fc = 0;
      return e;
    end
    k = kind_of(s);
    e.req = (s.mrm || s.mwm) && !m_err;
    case (k)
      K_HALT, K_MEMW: begin e.stall = 4'b1111; e.flush = 4'b0001; end
      K_BR:           begin e.stall = 4'b0000; e.flush = 4'b1110; end
      K_LU:           begin e.stall = 4'b1100; e.flush = 4'b0100; end
      default:        begin e.stall = 4'b0000; e.flush = 4'b0000; end
    endcase
    e.err = m_err; e.sc = m_sc; e.fc = m_fc;
    return e;
  endfunction

  task automatic advance(stim_t s);
    kind_t k;
    if (s.rst) begin
      m_err = 0; m_run = 0; m_sc = 0; m_fc = 0;
      return;
    end
    k = kind_of(s);
    if (k == K_HALT || k == K_MEMW || k == K_LU) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    if (k == K_BR) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    if (k == K_MEMW) begin
      m_run++;
      if (m_run == TMO) begin m_err = 1; m_run = 0; end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(stim_t s, string tag);
    Rs1D = s.rs1; Rs2D = s.rs2; RD_E = s.rd; MemReadE = s.mre;
    MemReadM = s.mrm; MemWriteM = s.mwm; PCSrcM = s.pcs;
    dmem_ready = s.rdy; reset = s.rst;
    q.push_back(predict(s, tag));
    @(posedge clk);
    advance(s);
    #1;
  endtask

  task automatic check(string name, string tag, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s [%s]: got %0h, expected %0h", name, tag, act, exp);
    end
  endtask

  // Monitor: every cycle carries a full output vector; compare at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        check("stall",       e.tag, 32'({StallF, StallD, StallE, StallM}), 32'(e.stall));
        check("flush",       e.tag, 32'({FlushD, FlushE, FlushM, FlushW}), 32'(e.flush));
        check("dmem_req",    e.tag, 32'(dmem_req), 32'(e.req));
        check("timeout_err", e.tag, 32'(mem_timeout_err), 32'(e.err));
        check("stall_count", e.tag, 32'(stall_count), 32'(e.sc));
        check("flush_count", e.tag, 32'(flush_count), 32'(e.fc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t idle, rst;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk);
    #1;

    step(rst, "reset0"); step(rst, "reset1"); step(idle, "idle");

    // Load-use on rs2, then the x0 destination that must not stall.
    step(mk(0, 5, 5, 1, 0, 0, 0, 1, 0), "lu");
    step(idle, "lu_after");
    step(mk(0, 0, 0, 1, 0, 0, 0, 1, 0), "lu_x0");

    // Branch beats a simultaneous load-use.
    step(mk(5, 0, 5, 1, 0, 0, 1, 1, 0), "br_lu");
    step(idle, "br_after");

    // Load waits three cycles then completes.
    step(rst, "mw_rst");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "mw_wait");
    step(mk(0, 0, 0, 0, 1, 0, 0, 1, 0), "mw_done");
    step(idle, "mw_after");

    // Branch held behind a memory stall, flushes when ready arrives.
    step(rst, "pr_rst");
    for (int i = 0; i < 2; i++) step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), "pr_wait");
    step(mk(0, 0, 0, 0, 0, 1, 1, 1, 0), "pr_ready");
    step(idle, "pr_after");

    // Store never acknowledged: timeout, sticky error, then reset clears.
    step(rst, "to_rst");
    for (int i = 0; i < 7; i++) step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), "to_stuck");
    step(idle, "to_err_idle");
    step(rst, "to_clear");
    step(idle, "to_after");

    // Continuous load-use saturates the stall counter.
    step(rst, "sat_rst");
    for (int i = 0; i < 20; i++) step(mk(3, 1, 3, 1, 0, 0, 0, 1, 0), "sat");
    step(idle, "sat_after");

    // Random traffic with small register numbers so hazards collide often.
    for (int i = 0; i < 600; i++) begin
      stim_t s;
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.mre = 1'($urandom % 2);
      s.mrm = ($urandom % 4) == 0;
      s.mwm = ($urandom % 4) == 0;
      s.pcs = ($urandom % 5) == 0;
      s.rdy = ($urandom % 5) < 3;
      s.rst = ($urandom % 40) == 0;
      step(s, "rand");
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
